// File: rtl/bnn_result_filter.sv
// bnn_result_filter: debounces the per-sample BNN class code. A class is accepted only
// after STABLE_COUNT consecutive equal valid samples. The accepted class is presented as
// a registered digit, a 7-segment pattern, a valid flag and a one-cycle update pulse.
module bnn_result_filter #(
    parameter int unsigned STABLE_COUNT = 4,   // 1..15
    parameter int unsigned TIMEOUT      = 255  // 0..255, 0 disables
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] class_in,
    input  logic       class_valid,
    output logic [3:0] digit,
    output logic [6:0] seg,
    output logic       digit_valid,
    output logic       update
);

    localparam logic [3:0] StableCnt  = STABLE_COUNT[3:0];
    localparam logic [8:0] TimeoutCnt = {1'b0, TIMEOUT[7:0]};
    localparam logic       TimeoutEn  = (TIMEOUT != 0);

    // Segment pattern for a normalised code; anything that is not 0-9 is a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        pat = 7'h40;
        case (code)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] idle_q, idle_d;
    logic       shown_q, shown_d;
    logic [3:0] digit_q, digit_d;
    logic [6:0] seg_q, seg_d;
    logic       digit_valid_q, digit_valid_d;
    logic       update_q, update_d;

    logic [3:0] norm;
    logic       is_empty;
    logic       is_locked;
    logic       extends_run;
    logic [3:0] new_cnt;
    logic       accept;
    logic [8:0] idle_inc;

    // Input normalisation and run bookkeeping shared by the next-state logic.
    always_comb begin
        norm = class_in;
        if (class_in >= 4'd10) begin
            norm = 4'hF;
        end
        is_empty    = (cnt_q == 4'd0);
        is_locked   = (cnt_q == StableCnt);
        extends_run = !is_empty && (norm == cand_q);
        if (extends_run) begin
            new_cnt = is_locked ? cnt_q : cnt_q + 4'd1;
        end else begin
            new_cnt = 4'd1;
        end
        // A restarted run counts as not-yet-locked, so STABLE_COUNT=1 accepts each new code.
        accept   = class_valid && (new_cnt == StableCnt) && !(extends_run && is_locked) &&
                   ((norm != digit_q) || !shown_q);
        idle_inc = {1'b0, idle_q} + 9'd1;
    end

    // Next-state for the run tracker, idle timer and output registers.
    always_comb begin
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        idle_d        = idle_q;
        shown_d       = shown_q;
        digit_d       = digit_q;
        seg_d         = seg_q;
        digit_valid_d = digit_valid_q;
        update_d      = 1'b0;

        if (class_valid) begin
            idle_d = 8'd0;
            cnt_d  = new_cnt;
            if (!extends_run) begin
                cand_d = norm;
            end
            if (accept) begin
                digit_d       = norm;
                seg_d         = seg_decode(norm);
                digit_valid_d = (norm <= 4'd9);
                shown_d       = 1'b1;
                update_d      = 1'b1;
            end
        end else begin
            // Gaps stall the run; only a long enough gap drops it.
            if (idle_q != 8'hFF) begin
                idle_d = idle_q + 8'd1;
            end
            if (TimeoutEn && (idle_inc == TimeoutCnt)) begin
                cnt_d  = 4'd0;
                idle_d = 8'd0;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q        <= 4'hF;
            cnt_q         <= 4'd0;
            idle_q        <= 8'd0;
            shown_q       <= 1'b0;
            digit_q       <= 4'hF;
            seg_q         <= 7'h00;
            digit_valid_q <= 1'b0;
            update_q      <= 1'b0;
        end else begin
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            idle_q        <= idle_d;
            shown_q       <= shown_d;
            digit_q       <= digit_d;
            seg_q         <= seg_d;
            digit_valid_q <= digit_valid_d;
            update_q      <= update_d;
        end
    end

    assign digit       = digit_q;
    assign seg         = seg_q;
    assign digit_valid = digit_valid_q;
    assign update      = update_q;

endmodule

// File: tb/tb_bnn_result_filter.sv
// Directed bench for bnn_result_filter with STABLE_COUNT=4, TIMEOUT=8.
module tb_bnn_result_filter;

    logic       clk;
    logic       reset;
    logic [3:0] class_in;
    logic       class_valid;
    logic [3:0] digit;
    logic [6:0] seg;
    logic       digit_valid;
    logic       update;

    int total;
    int bad;

    bnn_result_filter #(
        .STABLE_COUNT(4),
        .TIMEOUT     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .class_in   (class_in),
        .class_valid(class_valid),
        .digit      (digit),
        .seg        (seg),
        .digit_valid(digit_valid),
        .update     (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic step(input logic v, input logic [3:0] c);
        class_valid = v;
        class_in    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset       = 1'b1;
        class_valid = 1'b0;
        class_in    = 4'h0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic [6:0] s,
                           input logic dv, input logic up);
        chk({tag, ".digit"}, {4'h0, digit}, {4'h0, d});
        chk({tag, ".seg"}, {1'b0, seg}, {1'b0, s});
        chk({tag, ".dv"}, {7'h0, digit_valid}, {7'h0, dv});
        chk({tag, ".upd"}, {7'h0, update}, {7'h0, up});
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        class_in    = 4'h0;
        class_valid = 1'b0;

        // Reset and idle
        do_reset(2);
        chk_out("rst", 4'hF, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'h0);
            chk("idle.upd", {7'h0, update}, 8'h00);
        end
        chk_out("idle_end", 4'hF, 7'h00, 1'b0, 1'b0);

        // Four 3s accept on the 4th edge, a 5th gives no update
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd3);
            chk("run3.pre_upd", {7'h0, update}, 8'h00);
        end
        step(1'b1, 4'd3);
        chk_out("run3.acc", 4'd3, 7'h4F, 1'b1, 1'b1);
        step(1'b1, 4'd3);
        chk_out("run3.fifth", 4'd3, 7'h4F, 1'b1, 1'b0);

        // Broken run 7,7,7,2,7,7,7,7
        step(1'b1, 4'd7);
        step(1'b1, 4'd7);
        step(1'b1, 4'd7);
        chk_out("brk.after3", 4'd3, 7'h4F, 1'b1, 1'b0);
        step(1'b1, 4'd2);
        chk_out("brk.after2", 4'd3, 7'h4F, 1'b1, 1'b0);
        step(1'b1, 4'd7);
        step(1'b1, 4'd7);
        step(1'b1, 4'd7);
        chk_out("brk.pre", 4'd3, 7'h4F, 1'b1, 1'b0);
        step(1'b1, 4'd7);
        chk_out("brk.acc", 4'd7, 7'h07, 1'b1, 1'b1);
        step(1'b0, 4'd0);
        chk("brk.pulse_end", {7'h0, update}, 8'h00);

        // Gap of 3 invalid cycles stalls but does not break a run
        step(1'b1, 4'd5);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        step(1'b1, 4'd5);
        step(1'b1, 4'd5);
        chk_out("gap.pre", 4'd7, 7'h07, 1'b1, 1'b0);
        step(1'b1, 4'd5);
        chk_out("gap.acc", 4'd5, 7'h6D, 1'b1, 1'b1);

        // 8 invalid cycles time the run out
        step(1'b1, 4'd2);
        step(1'b1, 4'd2);
        step(1'b1, 4'd2);
        for (int i = 0; i < 8; i++) step(1'b0, 4'd0);
        step(1'b1, 4'd2);
        chk_out("tmo.first", 4'd5, 7'h6D, 1'b1, 1'b0);
        step(1'b1, 4'd2);
        step(1'b1, 4'd2);
        chk_out("tmo.third", 4'd5, 7'h6D, 1'b1, 1'b0);
        step(1'b1, 4'd2);
        chk_out("tmo.acc", 4'd2, 7'h5B, 1'b1, 1'b1);

        // Illegal code from reset shows a dash; following 15s are the same class
        do_reset(1);
        chk_out("ill.rst", 4'hF, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'd12);
        chk("ill.pre_upd", {7'h0, update}, 8'h00);
        step(1'b1, 4'd12);
        chk_out("ill.acc", 4'hF, 7'h40, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'd15);
            chk("ill.f_upd", {7'h0, update}, 8'h00);
        end
        chk_out("ill.f_end", 4'hF, 7'h40, 1'b0, 1'b0);

        // All of 10,11,13,14 normalise to the same class
        do_reset(1);
        step(1'b1, 4'd10);
        step(1'b1, 4'd11);
        step(1'b1, 4'd13);
        chk("mix.pre_upd", {7'h0, update}, 8'h00);
        step(1'b1, 4'd14);
        chk_out("mix.acc", 4'hF, 7'h40, 1'b0, 1'b1);

        // Reset mid-run loses the partial run and the shown digit
        for (int i = 0; i < 4; i++) step(1'b1, 4'd9);
        chk_out("mid.nine", 4'd9, 7'h6F, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'd6);
        do_reset(1);
        chk_out("mid.rst", 4'hF, 7'h00, 1'b0, 1'b0);
        step(1'b1, 4'd6);
        chk_out("mid.one6", 4'hF, 7'h00, 1'b0, 1'b0);
        step(1'b1, 4'd6);
        step(1'b1, 4'd6);
        chk_out("mid.three6", 4'hF, 7'h00, 1'b0, 1'b0);
        step(1'b1, 4'd6);
        chk_out("mid.acc", 4'd6, 7'h7D, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
